// File: rtl/timer_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : timer_pkg
// Purpose  : Shared types, LCD command bytes and BCD helpers for the
//            countdown_timer_lcd block.
// Contents : bcd_t / hms_t digit types, timer / LCD / nibble-writer state
//            enums, LCD command and ASCII constants, sanitise / decrement /
//            character-selection functions.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package timer_pkg;

   typedef logic [3:0] bcd_t;
   // [5]=hour tens, [4]=hour ones, [3]=min tens, [2]=min ones, [1]=sec tens, [0]=sec ones
   typedef bcd_t [5:0] hms_t;

   localparam logic [7:0] LCD_FUNC_4B = 8'h28;
   localparam logic [7:0] LCD_DISP_ON = 8'h0C;
   localparam logic [7:0] LCD_ENTRY   = 8'h06;
   localparam logic [7:0] LCD_CLEAR   = 8'h01;
   localparam logic [7:0] LCD_LINE1   = 8'h80;
   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_COLON = 8'h3A;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_PAUSE   = 2'd2,
      ST_EXPIRED = 2'd3
   } timer_state_t;

   typedef enum logic [2:0] {
      LS_WAIT_PWR = 3'd0,
      LS_INIT     = 3'd1,
      LS_CMDS     = 3'd2,
      LS_WAIT_CLR = 3'd3,
      LS_FRAME    = 3'd4
   } lcd_state_t;

   typedef enum logic [1:0] {
      NW_IDLE  = 2'd0,
      NW_SETUP = 2'd1,
      NW_HIGH  = 2'd2,
      NW_LOW   = 2'd3
   } nw_state_t;

   // Tens-of-seconds and tens-of-minutes digits top out at 5, all others at 9.
   function automatic bcd_t digit_max(input int i);
      return (i == 1 || i == 3) ? 4'd5 : 4'd9;
   endfunction

   function automatic hms_t hms_sanitise(input hms_t v);
      hms_t r;
      for (int i = 0; i < 6; i++) begin
         r[i] = (v[i] > digit_max(i)) ? digit_max(i) : v[i];
      end
      return r;
   endfunction

   // Ripple borrow from seconds ones upward; caller guarantees v != 0.
   function automatic hms_t hms_dec(input hms_t v);
      hms_t r;
      logic borrow;
      r      = v;
      borrow = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (borrow) begin
            if (r[i] == 4'd0) begin
               r[i] = digit_max(i);
            end else begin
               r[i]   = r[i] - 4'd1;
               borrow = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      case (idx)
         2'd0:    return LCD_FUNC_4B;
         2'd1:    return LCD_DISP_ON;
         2'd2:    return LCD_ENTRY;
         default: return LCD_CLEAR;
      endcase
   endfunction

   // Frame byte 0 is the cursor-home command, bytes 1..8 spell "HH:MM:SS".
   function automatic logic [7:0] frame_byte(input logic [3:0] idx, input hms_t s);
      case (idx)
         4'd0:    return LCD_LINE1;
         4'd1:    return ASCII_ZERO + {4'h0, s[5]};
         4'd2:    return ASCII_ZERO + {4'h0, s[4]};
         4'd3:    return ASCII_COLON;
         4'd4:    return ASCII_ZERO + {4'h0, s[3]};
         4'd5:    return ASCII_ZERO + {4'h0, s[2]};
         4'd6:    return ASCII_COLON;
         4'd7:    return ASCII_ZERO + {4'h0, s[1]};
         default: return ASCII_ZERO + {4'h0, s[0]};
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_nibble_writer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : lcd_nibble_writer
// Purpose  : Presents one {rs,nibble} to an HD44780 4-bit bus and strobes EN.
//            One setup cycle with EN low, EN high for EN_CYCLES, EN low for
//            EN_CYCLES, then ready again. rs/data only change while EN is low.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            valid/ready     - handshake, ready=1 only when idle
//            wr_rs/wr_nibble - register select and nibble to send
//            rs/en/data      - LCD pins
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module lcd_nibble_writer
   import timer_pkg::*;
#(
   parameter int EN_CYCLES = 800
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       valid,
   input  logic       wr_rs,
   input  logic [3:0] wr_nibble,
   output logic       ready,
   output logic       rs,
   output logic       en,
   output logic [3:0] data
);

   localparam int C_CW = (EN_CYCLES > 1) ? $clog2(EN_CYCLES) : 1;
   localparam logic [C_CW-1:0] C_LAST = C_CW'(EN_CYCLES - 1);

   nw_state_t       r_state, w_state_nxt;
   logic [C_CW-1:0] r_cnt, w_cnt_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= NW_IDLE;
         r_cnt   <= '0;
         rs      <= 1'b0;
         data    <= 4'h0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         // Latched on accept, while EN is still low.
         if (r_state == NW_IDLE && valid) begin
            rs   <= wr_rs;
            data <= wr_nibble;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         NW_IDLE:  if (valid) w_state_nxt = NW_SETUP;
         NW_SETUP: begin
            w_state_nxt = NW_HIGH;
            w_cnt_nxt   = '0;
         end
         NW_HIGH: begin
            if (r_cnt == C_LAST) begin
               w_state_nxt = NW_LOW;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + C_CW'(1);
            end
         end
         default: begin
            if (r_cnt == C_LAST) begin
               w_state_nxt = NW_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + C_CW'(1);
            end
         end
      endcase
   end

   assign en    = (r_state == NW_HIGH);
   assign ready = (r_state == NW_IDLE);

endmodule
`default_nettype wire

// File: rtl/countdown_timer_lcd.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : countdown_timer_lcd
// Purpose  : HH:MM:SS BCD countdown timer with preset/start/pause/reload,
//            expiry buzzer and an HD44780 4-bit LCD refresh engine.
// Ports    : clk, rst                        - clock, sync active-high reset
//            preset_bcd[23:0]                - HHMMSS preset, six BCD digits
//            load, start, pause, buzz_clr    - control (load highest priority)
//            running, expired, buzzer        - status / buzzer drive
//            rs, en, data[3:0]               - LCD pins (D7..D4)
// Config   : BUZZER_PULSE_EN - when defined the buzzer toggles every CLK_HZ/4
//            cycles during its active window instead of staying high.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module countdown_timer_lcd
   import timer_pkg::*;
#(
   parameter int CLK_HZ     = 12_000_000,
   parameter int INIT_WAIT  = 60_000,
   parameter int EN_CYCLES  = 800,
   parameter int CLEAR_WAIT = 24_000,
   parameter int BUZZ_SECS  = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [23:0] preset_bcd,
   input  logic        load,
   input  logic        start,
   input  logic        pause,
   input  logic        buzz_clr,
   output logic        running,
   output logic        expired,
   output logic        buzzer,
   output logic        rs,
   output logic        en,
   output logic [3:0]  data
);

   localparam int C_PW    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [C_PW-1:0] C_PRESC_LAST = C_PW'(CLK_HZ - 1);
   localparam int C_BSW   = (BUZZ_SECS > 1) ? $clog2(BUZZ_SECS + 1) : 1;
   localparam logic [C_BSW-1:0] C_BUZZ_LAST = C_BSW'((BUZZ_SECS > 0) ? BUZZ_SECS - 1 : 0);
   localparam int C_WMAX  = (INIT_WAIT > CLEAR_WAIT) ? INIT_WAIT : CLEAR_WAIT;
   localparam int C_WW    = (C_WMAX > 1) ? $clog2(C_WMAX) : 1;

   // ---------------- timer ----------------
   timer_state_t     r_state, w_state_nxt;
   hms_t             r_cnt, w_cnt_nxt;
   logic [C_PW-1:0]  r_presc, w_presc_nxt;
   logic             r_buzz, w_buzz_nxt;
   logic [C_PW-1:0]  r_bz_presc, w_bz_presc_nxt;
   logic [C_BSW-1:0] r_bz_secs, w_bz_secs_nxt;
   logic             w_tick, w_expire;

   assign w_tick = (r_state == ST_RUN) && (r_presc == C_PRESC_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_presc    <= '0;
         r_buzz     <= 1'b0;
         r_bz_presc <= '0;
         r_bz_secs  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_presc    <= w_presc_nxt;
         r_buzz     <= w_buzz_nxt;
         r_bz_presc <= w_bz_presc_nxt;
         r_bz_secs  <= w_bz_secs_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_presc_nxt    = r_presc;
      w_buzz_nxt     = r_buzz;
      w_bz_presc_nxt = r_bz_presc;
      w_bz_secs_nxt  = r_bz_secs;
      w_expire       = 1'b0;
      if (load) begin
         w_cnt_nxt   = hms_sanitise(hms_t'(preset_bcd));
         w_presc_nxt = '0;
         w_state_nxt = ST_IDLE;
         w_buzz_nxt  = 1'b0;
      end else if (buzz_clr) begin
         if (r_state == ST_EXPIRED) begin
            w_state_nxt = ST_IDLE;
            w_buzz_nxt  = 1'b0;
         end
      end else if (start && (r_state == ST_IDLE || r_state == ST_PAUSE)) begin
         // Prescaler is left alone so a resume finishes the interrupted second.
         w_state_nxt = ST_RUN;
      end else if (pause && r_state == ST_RUN) begin
         w_state_nxt = ST_PAUSE;
      end else if (r_state == ST_RUN) begin
         if (w_tick) begin
            w_presc_nxt = '0;
            if (r_cnt == '0) begin
               w_state_nxt    = ST_EXPIRED;
               w_buzz_nxt     = 1'b1;
               w_bz_presc_nxt = '0;
               w_bz_secs_nxt  = '0;
               w_expire       = 1'b1;
            end else begin
               w_cnt_nxt = hms_dec(r_cnt);
            end
         end else begin
            w_presc_nxt = r_presc + C_PW'(1);
         end
      end else if (r_state == ST_EXPIRED && r_buzz) begin
         // Independent one-second timebase measuring the buzzer window.
         if (r_bz_presc == C_PRESC_LAST) begin
            w_bz_presc_nxt = '0;
            if (BUZZ_SECS != 0 && r_bz_secs == C_BUZZ_LAST) w_buzz_nxt = 1'b0;
            else w_bz_secs_nxt = r_bz_secs + C_BSW'(1);
         end else begin
            w_bz_presc_nxt = r_bz_presc + C_PW'(1);
         end
      end
   end

   assign running = (r_state == ST_RUN);
   assign expired = (r_state == ST_EXPIRED);

`ifdef BUZZER_PULSE_EN
   localparam int C_BEEP  = (CLK_HZ / 4 > 0) ? CLK_HZ / 4 : 1;
   localparam int C_BEW   = (C_BEEP > 1) ? $clog2(C_BEEP) : 1;
   localparam logic [C_BEW-1:0] C_BEEP_LAST = C_BEW'(C_BEEP - 1);
   logic             r_beep;
   logic [C_BEW-1:0] r_beep_cnt;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_beep     <= 1'b0;
         r_beep_cnt <= '0;
      end else if (w_expire) begin
         r_beep     <= 1'b1;
         r_beep_cnt <= '0;
      end else if (r_buzz) begin
         if (r_beep_cnt == C_BEEP_LAST) begin
            r_beep_cnt <= '0;
            r_beep     <= ~r_beep;
         end else begin
            r_beep_cnt <= r_beep_cnt + C_BEW'(1);
         end
      end
   end
   assign buzzer = r_buzz & r_beep;
`else
   assign buzzer = r_buzz;
`endif

   // ---------------- LCD sequencer ----------------
   lcd_state_t      r_ls, w_ls_nxt;
   logic [3:0]      r_idx, w_idx_nxt;
   logic            r_lo, w_lo_nxt;
   logic [C_WW-1:0] r_wait, w_wait_nxt;
   hms_t            r_snap;
   logic            w_snap_take, w_valid, w_ready, w_wr_rs, w_accept;
   logic [3:0]      w_wr_nib;
   logic [7:0]      w_byte;

   assign w_accept = w_valid & w_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ls   <= LS_WAIT_PWR;
         r_idx  <= 4'd0;
         r_lo   <= 1'b0;
         r_wait <= '0;
         r_snap <= '0;
      end else begin
         r_ls   <= w_ls_nxt;
         r_idx  <= w_idx_nxt;
         r_lo   <= w_lo_nxt;
         r_wait <= w_wait_nxt;
         if (w_snap_take) r_snap <= r_cnt;
      end
   end

   always_comb begin
      w_ls_nxt    = r_ls;
      w_idx_nxt   = r_idx;
      w_lo_nxt    = r_lo;
      w_wait_nxt  = r_wait;
      w_snap_take = 1'b0;
      w_valid     = 1'b0;
      w_wr_rs     = 1'b0;
      w_byte      = 8'h00;
      w_wr_nib    = 4'h0;
      case (r_ls)
         LS_WAIT_PWR: begin
            if (r_wait == C_WW'(INIT_WAIT - 1)) begin
               w_ls_nxt   = LS_INIT;
               w_wait_nxt = '0;
               w_idx_nxt  = 4'd0;
            end else begin
               w_wait_nxt = r_wait + C_WW'(1);
            end
         end
         LS_INIT: begin
            w_valid  = 1'b1;
            w_wr_nib = (r_idx == 4'd3) ? 4'h2 : 4'h3;
            if (w_accept) begin
               if (r_idx == 4'd3) begin
                  w_ls_nxt  = LS_CMDS;
                  w_idx_nxt = 4'd0;
                  w_lo_nxt  = 1'b0;
               end else begin
                  w_idx_nxt = r_idx + 4'd1;
               end
            end
         end
         LS_CMDS: begin
            w_byte   = init_cmd(r_idx[1:0]);
            w_valid  = 1'b1;
            w_wr_nib = r_lo ? w_byte[3:0] : w_byte[7:4];
            if (w_accept) begin
               w_lo_nxt = ~r_lo;
               if (r_lo) begin
                  if (r_idx == 4'd3) begin
                     w_ls_nxt   = LS_WAIT_CLR;
                     w_wait_nxt = '0;
                  end else begin
                     w_idx_nxt = r_idx + 4'd1;
                  end
               end
            end
         end
         LS_WAIT_CLR: begin
            // Count only once the clear command's low nibble has fully left.
            if (w_ready) begin
               if (r_wait == C_WW'(CLEAR_WAIT - 1)) begin
                  w_ls_nxt   = LS_FRAME;
                  w_wait_nxt = '0;
                  w_idx_nxt  = 4'd0;
                  w_lo_nxt   = 1'b0;
               end else begin
                  w_wait_nxt = r_wait + C_WW'(1);
               end
            end
         end
         default: begin
            w_byte   = frame_byte(r_idx, r_snap);
            w_valid  = 1'b1;
            w_wr_rs  = (r_idx != 4'd0);
            w_wr_nib = r_lo ? w_byte[3:0] : w_byte[7:4];
            if (w_accept) begin
               // Snapshot on the home command so all eight chars agree.
               if (r_idx == 4'd0 && !r_lo) w_snap_take = 1'b1;
               w_lo_nxt = ~r_lo;
               if (r_lo) w_idx_nxt = (r_idx == 4'd8) ? 4'd0 : r_idx + 4'd1;
            end
         end
      endcase
   end

   lcd_nibble_writer #(
      .EN_CYCLES (EN_CYCLES)
   ) u_writer (
      .clk       (clk),
      .rst       (rst),
      .valid     (w_valid),
      .wr_rs     (w_wr_rs),
      .wr_nibble (w_wr_nib),
      .ready     (w_ready),
      .rs        (rs),
      .en        (en),
      .data      (data)
   );

endmodule
`default_nettype wire
